hilo_muldiv_unit: RTL



---
 rtl/hilo_muldiv_unit.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: iterative multiply/divide unit owning the HI/LO registers.
// Takes rs/rt read data for MULT/MULTU/DIV/DIVU/MTHI/MTLO and holds HI/LO for
// MFHI/MFLO. Multiply is shift-add and divide is restoring, one bit per cycle.
// Signed ops work on magnitudes, and the signs are fixed up in a final cycle.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO complete here in one edge
// MUL   | shift-add multiply, one multiplier bit per cycle (cnt 0..WIDTH-1)
// DIV   | restoring divide, one quotient bit per cycle (cnt 0..WIDTH-1)
// FIX   | sign correction, HI/LO write, done pulse on exit
module hilo_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t               state, state_nxt;
  // acc holds {partial product high, multiplier} in MUL and {remainder, dividend/quotient} in DIV
  logic [2*WIDTH-1:0]   acc, acc_nxt;
  logic [WIDTH-1:0]     opb, opb_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic                 is_div, is_div_nxt;
  logic                 neg_lo, neg_lo_nxt;
  logic                 neg_hi, neg_hi_nxt;
  logic                 dz_pend, dz_pend_nxt;
  logic [WIDTH-1:0]     hi_nxt, lo_nxt;
  logic                 done_nxt, div_zero_nxt;

  logic                 signed_op;
  logic                 div_op;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_shift;
  logic                 div_ge;
  logic [WIDTH-1:0]     div_diff;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  assign signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign div_op    = (op == OP_DIV) || (op == OP_DIVU);
  assign a_mag     = (signed_op && a[WIDTH-1]) ? -a : a;
  assign b_mag     = (signed_op && b[WIDTH-1]) ? -b : b;

  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);

  // bit WIDTH of the shifted remainder only matters for the compare; when the
  // subtract happens the true difference is below opb, so WIDTH bits suffice
  assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, opb};
  assign div_diff  = div_shift[WIDTH-1:0] - opb;

  assign prod_fix  = neg_lo ? -acc : acc;
  assign quo_fix   = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix   = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  assign busy      = (state != IDLE);

  // Next-state, datapath step and output pulse selection
  always_comb begin
    state_nxt    = state;
    acc_nxt      = acc;
    opb_nxt      = opb;
    cnt_nxt      = cnt;
    is_div_nxt   = is_div;
    neg_lo_nxt   = neg_lo;
    neg_hi_nxt   = neg_hi;
    dz_pend_nxt  = dz_pend;
    hi_nxt       = hi;
    lo_nxt       = lo;
    done_nxt     = 1'b0;
    div_zero_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              acc_nxt     = {{WIDTH{1'b0}}, a_mag};
              opb_nxt     = b_mag;
              cnt_nxt     = '0;
              is_div_nxt  = div_op;
              neg_lo_nxt  = signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_hi_nxt  = signed_op && a[WIDTH-1];
              dz_pend_nxt = div_op && (b == '0);
              state_nxt   = div_op ? DIV : MUL;
            end
            OP_MTHI: begin
              hi_nxt   = a;
              done_nxt = 1'b1;
            end
            OP_MTLO: begin
              lo_nxt   = a;
              done_nxt = 1'b1;
            end
            default: ;
          endcase
        end
      end
      MUL: begin
        acc_nxt = {mul_sum, acc[WIDTH-1:1]};
        cnt_nxt = cnt + 1'b1;
        if (cnt == CNT_LAST) state_nxt = FIX;
      end
      DIV: begin
        acc_nxt = div_ge ? {div_diff, acc[WIDTH-2:0], 1'b1}
                         : {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        cnt_nxt = cnt + 1'b1;
        if (cnt == CNT_LAST) state_nxt = FIX;
      end
      FIX: begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
        if (is_div) begin
          if (dz_pend) begin
            div_zero_nxt = 1'b1;
          end else begin
            hi_nxt = rem_fix;
            lo_nxt = quo_fix;
          end
        end else begin
          {hi_nxt, lo_nxt} = prod_fix;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low clear
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      acc      <= '0;
      opb      <= '0;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      dz_pend  <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state    <= state_nxt;
      acc      <= acc_nxt;
      opb      <= opb_nxt;
      cnt      <= cnt_nxt;
      is_div   <= is_div_nxt;
      neg_lo   <= neg_lo_nxt;
      neg_hi   <= neg_hi_nxt;
      dz_pend  <= dz_pend_nxt;
      hi       <= hi_nxt;
      lo       <= lo_nxt;
      done     <= done_nxt;
      div_zero <= div_zero_nxt;
    end
  end

endmodule
